// File: rtl/apb_master.sv
//==============================================================================
// Module      : apb_master
// Description : Single-outstanding APB requester. Accepts one command at a
//               time through a valid/ready handshake, runs the APB
//               SETUP/ACCESS sequence, then reports completion with a
//               one-cycle rsp_valid pulse carrying read data, the slave error
//               and a timeout flag. An optional wait-state timeout ends
//               transfers whose slave never raises pready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   DATA_LENGTH    : width of pwdata/prdata and command/response data
//   ADDRESS_LENGTH : width of paddr and cmd_addr
//   TIMEOUT_CYCLES : max ACCESS cycles without pready (0 = no timeout)
// Ports
//   from_top_clk   : clock, all state changes on its rising edge
//   preset         : asynchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake
//   cmd_write/cmd_addr/cmd_wdata   : command direction, address, write data
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout : completion response
//   psel/penable/pwrite/paddr/pwdata        : APB requester outputs
//   pready/prdata/pslverr                   : APB completer inputs
//==============================================================================
`default_nettype none

module apb_master #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      from_top_clk,
  input  logic                      preset,
  // command channel
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_LENGTH-1:0] cmd_addr,
  input  logic [DATA_LENGTH-1:0]    cmd_wdata,
  // response channel
  output logic                      rsp_valid,
  output logic [DATA_LENGTH-1:0]    rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  // APB requester
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_LENGTH-1:0] paddr,
  output logic [DATA_LENGTH-1:0]    pwdata,
  input  logic                      pready,
  input  logic [DATA_LENGTH-1:0]    prdata,
  input  logic                      pslverr
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;

  // Counter wide enough to hold TIMEOUT_CYCLES; one bit when disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The transfer times out on the ACCESS cycle that would bring the count
  // to TIMEOUT_CYCLES, so after exactly TIMEOUT_CYCLES stalled cycles.
  localparam logic [CNT_W-1:0] c_TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;

  // Acceptance uses the state directly; cmd_ready carries no path from
  // cmd_valid.
  assign w_accept = (r_state == c_IDLE) && cmd_valid;
  // A pready in the last allowed cycle wins over the timeout.
  assign w_done   = (r_state == c_ACCESS) && pready;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign w_timeout = (r_state == c_ACCESS) && !pready &&
                         (r_wait_cnt == c_TMO_LAST);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge from_top_clk or posedge preset) begin
    if (preset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (cmd_valid) begin
          w_next_state = c_SETUP;
        end
      end
      // pready is deliberately ignored in SETUP.
      c_SETUP: begin
        w_next_state = c_ACCESS;
      end
      c_ACCESS: begin
        if (w_done || w_timeout) begin
          w_next_state = c_IDLE;
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Output decode
  //--------------------------------------------------------------------------
  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    cmd_ready = 1'b0;
    case (r_state)
      c_IDLE: begin
        // Held low while reset is asserted, high from the first cycle after.
        cmd_ready = !preset;
      end
      c_SETUP: begin
        psel = 1'b1;
      end
      c_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      default: begin
        psel      = 1'b0;
        penable   = 1'b0;
        cmd_ready = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Command capture: address/data/direction are loaded only on acceptance,
  // so they stay stable for the whole transfer and hold through IDLE.
  //--------------------------------------------------------------------------
  always_ff @(posedge from_top_clk or posedge preset) begin
    if (preset) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (w_accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  //--------------------------------------------------------------------------
  // Wait-state counter: cleared while in SETUP (i.e. on entry to ACCESS),
  // counts stalled ACCESS cycles, saturates so it never wraps when the
  // timeout is disabled.
  //--------------------------------------------------------------------------
  always_ff @(posedge from_top_clk or posedge preset) begin
    if (preset) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == c_ACCESS) && !pready && (r_wait_cnt != '1)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Response: one-cycle pulse after completion or timeout; data and flags
  // hold until the next completion. prdata/pslverr are sampled only on a
  // real completion.
  //--------------------------------------------------------------------------
  always_ff @(posedge from_top_clk or posedge preset) begin
    if (preset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (w_done) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= pwrite ? '0 : prdata;
      rsp_err     <= pslverr;
      rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end else begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

`default_nettype wire
